// File: rtl/ex_result_arbiter.sv
// EX-stage result arbiter: four producers (two multipliers, two ALUs) onto two
// registered writeback buses, with a one-entry hold register per producer.
module ex_result_arbiter (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic [3:0]   src_valid_in,
    input  logic [127:0] src_IR_in,
    input  logic [255:0] src_NPC_in,
    input  logic [19:0]  src_dest_reg_in,
    input  logic [255:0] src_result_in,
    output logic         stall_alu_1,
    output logic         stall_alu_2,
    output logic [1:0]   bus_valid_out,
    output logic [63:0]  bus_IR_out,
    output logic [127:0] bus_NPC_out,
    output logic [9:0]   bus_dest_reg_out,
    output logic [127:0] bus_result_out
);

    localparam int unsigned NSRC   = 4;
    localparam int unsigned NBUS   = 2;
    localparam int unsigned NCAND  = 2 * NSRC;
    localparam int unsigned IR_W   = 32;
    localparam int unsigned NPC_W  = 64;
    localparam int unsigned DEST_W = 5;
    localparam int unsigned RES_W  = 64;

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [NPC_W-1:0]  npc;
        logic [DEST_W-1:0] dest;
        logic [RES_W-1:0]  result;
    } payload_t;

    payload_t            src_pl   [NSRC];
    payload_t            hold_q   [NSRC];
    payload_t            bus_d    [NBUS];
    payload_t            bus_q    [NBUS];
    logic [NSRC-1:0]     hold_valid;
    logic [NSRC-1:0]     hold_valid_d;
    logic [NSRC-1:0]     fresh;
    logic [NSRC-1:0]     capture;
    logic [NCAND-1:0]    cand;
    logic [NCAND-1:0]    granted;
    logic [NBUS-1:0]     g_valid;
    logic [2:0]          g_idx    [NBUS];
    logic [NBUS-1:0]     bus_valid_q;

    // Unpack the flat producer buses.
    always_comb begin
        for (int i = 0; i < int'(NSRC); i++) begin
            src_pl[i].ir     = src_IR_in[IR_W*i +: IR_W];
            src_pl[i].npc    = src_NPC_in[NPC_W*i +: NPC_W];
            src_pl[i].dest   = src_dest_reg_in[DEST_W*i +: DEST_W];
            src_pl[i].result = src_result_in[RES_W*i +: RES_W];
        end
    end

    // A holding source's input is a repeat (ALU stall) and is ignored.
    assign fresh = src_valid_in & ~hold_valid;
    assign cand  = {fresh, hold_valid};

    // First two candidates in index order win: held 0..3, then fresh 0..3.
    always_comb begin
        g_valid  = '0;
        g_idx[0] = '0;
        g_idx[1] = '0;
        for (int k = 0; k < int'(NCAND); k++) begin
            if (cand[k]) begin
                if (!g_valid[0]) begin
                    g_valid[0] = 1'b1;
                    g_idx[0]   = 3'(k);
                end else if (!g_valid[1]) begin
                    g_valid[1] = 1'b1;
                    g_idx[1]   = 3'(k);
                end
            end
        end
    end

    always_comb begin
        granted = '0;
        for (int b = 0; b < int'(NBUS); b++) begin
            if (g_valid[b]) begin
                granted[g_idx[b]] = 1'b1;
            end
            bus_d[b] = g_idx[b][2] ? src_pl[g_idx[b][1:0]] : hold_q[g_idx[b][1:0]];
        end
    end

    assign capture      = fresh & ~granted[NCAND-1:NSRC];
    assign hold_valid_d = (hold_valid & ~granted[NSRC-1:0]) | capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid  <= '0;
            bus_valid_q <= '0;
            for (int i = 0; i < int'(NSRC); i++) begin
                hold_q[i] <= '0;
            end
            for (int b = 0; b < int'(NBUS); b++) begin
                bus_q[b] <= '0;
            end
        end else if (flush) begin
            hold_valid  <= '0;
            bus_valid_q <= '0;
        end else begin
            hold_valid  <= hold_valid_d;
            bus_valid_q <= g_valid;
            for (int i = 0; i < int'(NSRC); i++) begin
                if (capture[i]) begin
                    hold_q[i] <= src_pl[i];
                end
            end
            for (int b = 0; b < int'(NBUS); b++) begin
                bus_q[b] <= bus_d[b];
            end
        end
    end

    // Flatten the registered bus payloads.
    always_comb begin
        for (int b = 0; b < int'(NBUS); b++) begin
            bus_IR_out[IR_W*b +: IR_W]           = bus_q[b].ir;
            bus_NPC_out[NPC_W*b +: NPC_W]        = bus_q[b].npc;
            bus_dest_reg_out[DEST_W*b +: DEST_W] = bus_q[b].dest;
            bus_result_out[RES_W*b +: RES_W]     = bus_q[b].result;
        end
    end

    assign bus_valid_out = bus_valid_q;
    assign stall_alu_1   = hold_valid[2];
    assign stall_alu_2   = hold_valid[3];

endmodule

// File: tb/tb_ex_result_arbiter.sv
// Directed bench for ex_result_arbiter: a vector table replayed back-to-back,
// plus hand-written flush and reset sequences.
module tb_ex_result_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic         flush;
    logic [3:0]   src_valid_in;
    logic [127:0] src_IR_in;
    logic [255:0] src_NPC_in;
    logic [19:0]  src_dest_reg_in;
    logic [255:0] src_result_in;
    logic         stall_alu_1;
    logic         stall_alu_2;
    logic [1:0]   bus_valid_out;
    logic [63:0]  bus_IR_out;
    logic [127:0] bus_NPC_out;
    logic [9:0]   bus_dest_reg_out;
    logic [127:0] bus_result_out;

    int n_vec = 0;
    int n_err = 0;

    ex_result_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .flush            (flush),
        .src_valid_in     (src_valid_in),
        .src_IR_in        (src_IR_in),
        .src_NPC_in       (src_NPC_in),
        .src_dest_reg_in  (src_dest_reg_in),
        .src_result_in    (src_result_in),
        .stall_alu_1      (stall_alu_1),
        .stall_alu_2      (stall_alu_2),
        .bus_valid_out    (bus_valid_out),
        .bus_IR_out       (bus_IR_out),
        .bus_NPC_out      (bus_NPC_out),
        .bus_dest_reg_out (bus_dest_reg_out),
        .bus_result_out   (bus_result_out)
    );

    always #5 clock = ~clock;

    // Payload of source s tagged t; unique per (s, t).
    function automatic logic [31:0] mk_ir(int s, logic [7:0] t);
        return {16'hC0DE, 8'(s), t};
    endfunction
    function automatic logic [63:0] mk_npc(int s, logic [7:0] t);
        return {32'h8000_0000, 16'(s), 8'h00, t};
    endfunction
    function automatic logic [4:0] mk_dest(int s, logic [7:0] t);
        return 5'((s * 8) + int'(t));
    endfunction
    function automatic logic [63:0] mk_res(int s, logic [7:0] t);
        return {24'hABCDEF, 8'(s), 24'h000000, t};
    endfunction

    task automatic drive(input logic [3:0] v, input logic [7:0] t);
        src_valid_in = v;
        for (int s = 0; s < 4; s++) begin
            src_IR_in[32*s +: 32]      = mk_ir(s, t);
            src_NPC_in[64*s +: 64]     = mk_npc(s, t);
            src_dest_reg_in[5*s +: 5]  = mk_dest(s, t);
            src_result_in[64*s +: 64]  = mk_res(s, t);
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input int b, input int s, input logic [7:0] t);
        chk($sformatf("%s_b%0d_ir", name, b),   128'(bus_IR_out[32*b +: 32]),     128'(mk_ir(s, t)));
        chk($sformatf("%s_b%0d_npc", name, b),  128'(bus_NPC_out[64*b +: 64]),    128'(mk_npc(s, t)));
        chk($sformatf("%s_b%0d_dest", name, b), 128'(bus_dest_reg_out[5*b +: 5]), 128'(mk_dest(s, t)));
        chk($sformatf("%s_b%0d_res", name, b),  128'(bus_result_out[64*b +: 64]), 128'(mk_res(s, t)));
    endtask

    task automatic chk_zero_payload(input string name);
        chk({name, "_ir"},   128'(bus_IR_out),       128'(0));
        chk({name, "_npc"},  bus_NPC_out,            128'(0));
        chk({name, "_dest"}, 128'(bus_dest_reg_out), 128'(0));
        chk({name, "_res"},  bus_result_out,         128'(0));
    endtask

    // A multiplier must never present a result while its hold register is full.
    task automatic step();
        chk("mult_hold_overflow", 128'(src_valid_in[1:0] & dut.hold_valid[1:0]), 128'(0));
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [1:0] bv;
        int         s0;
        logic [7:0] t0;
        int         s1;
        logic [7:0] t1;
        logic [1:0] stall;  // {stall_alu_2, stall_alu_1}
    } vec_t;

    vec_t vt [16];

    initial begin
        // Inputs of entry k carry tag k; expectations describe the cycle after.
        vt[0]  = '{4'b0100, 2'b01, 2, 8'd0,  0, 8'd0,  2'b00};  // lone ALU1
        vt[1]  = '{4'b1111, 2'b11, 0, 8'd1,  1, 8'd1,  2'b11};  // all four
        vt[2]  = '{4'b1100, 2'b11, 2, 8'd1,  3, 8'd1,  2'b00};  // held ALUs drain
        vt[3]  = '{4'b0000, 2'b00, 0, 8'd0,  0, 8'd0,  2'b00};
        vt[4]  = '{4'b1011, 2'b11, 0, 8'd4,  1, 8'd4,  2'b10};  // ALU2 held
        vt[5]  = '{4'b1101, 2'b11, 3, 8'd4,  0, 8'd5,  2'b01};  // mixed priority
        vt[6]  = '{4'b0100, 2'b01, 2, 8'd5,  0, 8'd0,  2'b00};
        vt[7]  = '{4'b0011, 2'b11, 0, 8'd7,  1, 8'd7,  2'b00};  // mult stream
        vt[8]  = '{4'b0011, 2'b11, 0, 8'd8,  1, 8'd8,  2'b00};
        vt[9]  = '{4'b1111, 2'b11, 0, 8'd9,  1, 8'd9,  2'b11};
        vt[10] = '{4'b1100, 2'b11, 2, 8'd9,  3, 8'd9,  2'b00};
        vt[11] = '{4'b0000, 2'b00, 0, 8'd0,  0, 8'd0,  2'b00};
        vt[12] = '{4'b0010, 2'b01, 1, 8'd12, 0, 8'd0,  2'b00};  // lone mult2 -> bus 1
        vt[13] = '{4'b1000, 2'b01, 3, 8'd13, 0, 8'd0,  2'b00};  // lone ALU2 -> bus 1
        vt[14] = '{4'b1100, 2'b11, 2, 8'd14, 3, 8'd14, 2'b00};
        vt[15] = '{4'b0000, 2'b00, 0, 8'd0,  0, 8'd0,  2'b00};

        reset = 1'b1;
        flush = 1'b0;
        drive(4'b0000, 8'd0);
        step();
        step();
        chk("rst_bus_valid", 128'(bus_valid_out), 128'(0));
        chk("rst_stalls", 128'({stall_alu_2, stall_alu_1}), 128'(0));
        chk_zero_payload("rst");
        reset = 1'b0;

        // Lone ALU1 result with literal payload values.
        drive(4'b0100, 8'd0);
        src_result_in[128 +: 64] = 64'h5;
        src_dest_reg_in[10 +: 5] = 5'd3;
        step();
        chk("single_bus_valid", 128'(bus_valid_out), 128'(2'b01));
        chk("single_result", 128'(bus_result_out[63:0]), 128'(64'h5));
        chk("single_dest", 128'(bus_dest_reg_out[4:0]), 128'(5'd3));
        chk("single_stall_alu_1", 128'(stall_alu_1), 128'(0));
        drive(4'b0000, 8'd0);
        step();

        for (int k = 0; k < 16; k++) begin
            drive(vt[k].valid, 8'(k));
            step();
            chk($sformatf("v%0d_bus_valid", k), 128'(bus_valid_out), 128'(vt[k].bv));
            chk($sformatf("v%0d_stalls", k), 128'({stall_alu_2, stall_alu_1}), 128'(vt[k].stall));
            if (vt[k].bv[0]) chk_bus($sformatf("v%0d", k), 0, vt[k].s0, vt[k].t0);
            if (vt[k].bv[1]) chk_bus($sformatf("v%0d", k), 1, vt[k].s1, vt[k].t1);
        end

        // Flush while both ALUs are held; fresh mults in the flush cycle are dropped.
        drive(4'b1111, 8'hF0);
        step();
        chk("fl_bus_valid", 128'(bus_valid_out), 128'(2'b11));
        chk("fl_stalls", 128'({stall_alu_2, stall_alu_1}), 128'(2'b11));
        chk_bus("fl", 0, 0, 8'hF0);
        chk_bus("fl", 1, 1, 8'hF0);
        flush = 1'b1;
        drive(4'b1111, 8'hF1);
        step();
        flush = 1'b0;
        chk("fl_post_bus_valid", 128'(bus_valid_out), 128'(0));
        chk("fl_post_stalls", 128'({stall_alu_2, stall_alu_1}), 128'(0));
        drive(4'b0000, 8'd0);
        step();
        chk("fl_drain_bus_valid", 128'(bus_valid_out), 128'(0));
        step();
        chk("fl_drain2_bus_valid", 128'(bus_valid_out), 128'(0));

        // Reset with both ALUs held (hold_valid = 4'b1100).
        drive(4'b1111, 8'hE0);
        step();
        chk("mr_pre_stalls", 128'({stall_alu_2, stall_alu_1}), 128'(2'b11));
        reset = 1'b1;
        drive(4'b1111, 8'hE1);
        step();
        reset = 1'b0;
        chk("mr_bus_valid", 128'(bus_valid_out), 128'(0));
        chk("mr_stalls", 128'({stall_alu_2, stall_alu_1}), 128'(0));
        chk_zero_payload("mr");
        drive(4'b0000, 8'd0);
        step();
        chk("mr_idle_bus_valid", 128'(bus_valid_out), 128'(0));
        drive(4'b1000, 8'hE3);
        step();
        chk("mr_alu2_bus_valid", 128'(bus_valid_out), 128'(2'b01));
        chk_bus("mr_alu2", 0, 3, 8'hE3);
        chk("mr_alu2_stalls", 128'({stall_alu_2, stall_alu_1}), 128'(0));
        drive(4'b0000, 8'd0);
        step();
        chk("mr_end_bus_valid", 128'(bus_valid_out), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
